// File: rtl/cmp_search_if.sv
// Probe/verdict and start/result bundle for cmp_search.
// master: the search initiator; slave: its controller and cmp responder side.
interface cmp_search_if #(
    parameter int unsigned W = 32
);
    localparam int unsigned IterW = $clog2(W + 2);

    logic             i_start;
    logic [W-1:0]     i_lo;
    logic [W-1:0]     i_hi;
    logic             o_busy;
    logic             o_probe_vld;
    logic             i_probe_rdy;
    logic [W-1:0]     o_probe;
    logic             i_rsp_vld;
    logic             i_eq;
    logic             i_gt;
    logic             i_lt;
    logic             o_done;
    logic             o_found;
    logic             o_err;
    logic [W-1:0]     o_result;
    logic [IterW-1:0] o_iters;

    modport master (
        input  i_start, i_lo, i_hi, i_probe_rdy, i_rsp_vld, i_eq, i_gt, i_lt,
        output o_busy, o_probe_vld, o_probe, o_done, o_found, o_err, o_result, o_iters
    );

    modport slave (
        output i_start, i_lo, i_hi, i_probe_rdy, i_rsp_vld, i_eq, i_gt, i_lt,
        input  o_busy, o_probe_vld, o_probe, o_done, o_found, o_err, o_result, o_iters
    );
endinterface

// File: rtl/cmp_search.sv
// Binary-search initiator: issues probes to a cmp responder and narrows [lo, hi] on its verdicts.
// Optional response watchdog enabled by defining CMP_SEARCH_TIMEOUT_EN.
module cmp_search #(
    parameter int unsigned W         = 32,
    parameter bit          IS_SIGNED = 1'b1,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic          clk,
    input logic          rst,
    cmp_search_if.master bus
);
    localparam int unsigned IterW = $clog2(W + 2);
    // Flipping the MSB maps two's-complement order onto unsigned order.
    localparam logic [W-1:0] Flip = IS_SIGNED ? {1'b1, {(W - 1){1'b0}}} : {W{1'b0}};
    localparam logic [W:0]   One  = {{W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e           state_q;
    logic [W:0]       lo_q, hi_q;
    logic [W-1:0]     probe_q, result_q;
    logic [IterW-1:0] iters_q;
    logic             busy_q, vld_q, done_q, found_q, err_q;

    logic [W:0] lo_in, hi_in, mid, mid_start, mid_dn, mid_up;
    logic [2:0] verdict;
    logic       unused_msb;

    assign lo_in     = {1'b0, bus.i_lo ^ Flip};
    assign hi_in     = {1'b0, bus.i_hi ^ Flip};
    assign mid       = lo_q + ((hi_q - lo_q) >> 1);
    assign mid_start = lo_in + ((hi_in - lo_in) >> 1);
    // Next probe after a gt/lt verdict; only used when the edge guard has not fired.
    assign mid_dn    = lo_q + (((mid - One) - lo_q) >> 1);
    assign mid_up    = (mid + One) + ((hi_q - (mid + One)) >> 1);
    assign verdict   = {bus.i_eq, bus.i_gt, bus.i_lt};
    assign unused_msb = ^{mid_start[W], mid_dn[W], mid_up[W]};

`ifdef CMP_SEARCH_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0] tmo_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            result_q <= '0;
            iters_q  <= '0;
            busy_q   <= 1'b0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef CMP_SEARCH_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        lo_q    <= lo_in;
                        hi_q    <= hi_in;
                        iters_q <= '0;
                        found_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (lo_in > hi_in) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= bus.i_lo;
                        end else begin
                            state_q <= StIssue;
                            vld_q   <= 1'b1;
                            probe_q <= mid_start[W-1:0] ^ Flip;
                        end
                    end
                end
                StIssue: begin
                    if (bus.i_probe_rdy) begin
                        vld_q   <= 1'b0;
                        iters_q <= iters_q + IterW'(1);
                        state_q <= StWait;
`ifdef CMP_SEARCH_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                end
                StWait: begin
                    if (bus.i_rsp_vld) begin
                        case (verdict)
                            3'b100: begin
                                state_q  <= StDone;
                                done_q   <= 1'b1;
                                found_q  <= 1'b1;
                                result_q <= probe_q;
                            end
                            3'b010: begin
                                if (mid == lo_q) begin
                                    state_q  <= StDone;
                                    done_q   <= 1'b1;
                                    result_q <= probe_q;
                                end else begin
                                    hi_q    <= mid - One;
                                    probe_q <= mid_dn[W-1:0] ^ Flip;
                                    vld_q   <= 1'b1;
                                    state_q <= StIssue;
                                end
                            end
                            3'b001: begin
                                if (mid == hi_q) begin
                                    state_q  <= StDone;
                                    done_q   <= 1'b1;
                                    result_q <= probe_q;
                                end else begin
                                    lo_q    <= mid + One;
                                    probe_q <= mid_up[W-1:0] ^ Flip;
                                    vld_q   <= 1'b1;
                                    state_q <= StIssue;
                                end
                            end
                            default: begin
                                state_q  <= StDone;
                                done_q   <= 1'b1;
                                err_q    <= 1'b1;
                                found_q  <= 1'b0;
                                result_q <= probe_q;
                            end
                        endcase
                    end
`ifdef CMP_SEARCH_TIMEOUT_EN
                    else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                        state_q  <= StDone;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        found_q  <= 1'b0;
                        result_q <= probe_q;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_probe_vld = vld_q;
    assign bus.o_probe     = probe_q;
    assign bus.o_done      = done_q;
    assign bus.o_found     = found_q;
    assign bus.o_err       = err_q;
    assign bus.o_result    = result_q;
    assign bus.o_iters     = iters_q;
endmodule

// File: tb/tb_cmp_search.sv
// Drives an unsigned and a signed cmp_search (W=8) with shared start/bounds and a behavioural
// responder each; results are checked against an integer binary-search reference.
module tb_cmp_search;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [7:0] lo_v, hi_v;
    logic rdy[2], rsp_vld[2], eq[2], gt[2], lt[2];
    logic busy_w[2], vld_w[2], done_w[2], found_w[2], err_w[2];
    logic [7:0] probe_w[2], result_w[2];
    logic [3:0] iters_w[2];

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;

    cmp_search_if #(.W(8)) if_u ();
    cmp_search_if #(.W(8)) if_s ();

    cmp_search #(.W(8), .IS_SIGNED(1'b0), .TIMEOUT(8)) u_dut_u (.clk(clk), .rst(rst), .bus(if_u));
    cmp_search #(.W(8), .IS_SIGNED(1'b1), .TIMEOUT(8)) u_dut_s (.clk(clk), .rst(rst), .bus(if_s));

    assign if_u.i_start = start;       assign if_s.i_start = start;
    assign if_u.i_lo = lo_v;           assign if_s.i_lo = lo_v;
    assign if_u.i_hi = hi_v;           assign if_s.i_hi = hi_v;
    assign if_u.i_probe_rdy = rdy[0];  assign if_s.i_probe_rdy = rdy[1];
    assign if_u.i_rsp_vld = rsp_vld[0]; assign if_s.i_rsp_vld = rsp_vld[1];
    assign if_u.i_eq = eq[0];          assign if_s.i_eq = eq[1];
    assign if_u.i_gt = gt[0];          assign if_s.i_gt = gt[1];
    assign if_u.i_lt = lt[0];          assign if_s.i_lt = lt[1];

    assign busy_w[0] = if_u.o_busy;        assign busy_w[1] = if_s.o_busy;
    assign vld_w[0] = if_u.o_probe_vld;    assign vld_w[1] = if_s.o_probe_vld;
    assign done_w[0] = if_u.o_done;        assign done_w[1] = if_s.o_done;
    assign found_w[0] = if_u.o_found;      assign found_w[1] = if_s.o_found;
    assign err_w[0] = if_u.o_err;          assign err_w[1] = if_s.o_err;
    assign probe_w[0] = if_u.o_probe;      assign probe_w[1] = if_s.o_probe;
    assign result_w[0] = if_u.o_result;    assign result_w[1] = if_s.o_result;
    assign iters_w[0] = if_u.o_iters;      assign iters_w[1] = if_s.o_iters;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int d, input string s);
        return $sformatf("%s_%s", (d != 0) ? "s" : "u", s);
    endfunction

    // d=0 reads bytes as unsigned, d=1 as two's complement.
    function automatic int val(input int d, input logic [7:0] x);
        return (d != 0) ? int'($signed(x)) : int'(x);
    endfunction

    function automatic logic [2:0] verdict(input int d, input logic [7:0] p, input logic [7:0] t);
        if (val(d, p) == val(d, t)) return 3'b100;
        if (val(d, p) > val(d, t)) return 3'b010;
        return 3'b001;
    endfunction

    function automatic void model(input int d, input logic [7:0] lo, input logic [7:0] hi,
                                  input logic [7:0] tgt, output int found,
                                  output logic [7:0] res, output int iters);
        int l, h, t, m;
        l = val(d, lo);
        h = val(d, hi);
        t = val(d, tgt);
        found = 0;
        res = lo;
        iters = 0;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
        while (l <= h) begin
            m = l + (h - l) / 2;
            iters++;
            res = 8'(m);
            if (d == 0) exp_q0.push_back(8'(m)); else exp_q1.push_back(8'(m));
            if (m == t) begin
                found = 1;
                break;
            end
            if (m > t) h = m - 1; else l = m + 1;
        end
    endfunction

    function automatic void pop_exp(input int d, output bit ok, output logic [7:0] v);
        ok = 1'b0;
        v = '0;
        if (d == 0) begin
            if (exp_q0.size() > 0) begin ok = 1'b1; v = exp_q0.pop_front(); end
        end else begin
            if (exp_q1.size() > 0) begin ok = 1'b1; v = exp_q1.pop_front(); end
        end
    endfunction

    task automatic idle_inputs();
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rdy[d] = 1'b0; rsp_vld[d] = 1'b0; eq[d] = 1'b0; gt[d] = 1'b0; lt[d] = 1'b0;
        end
    endtask

    // mode 0 normal, 1 bad verdict, 2 rdy held low 10 cycles, 3 no response, 4 reset in WAIT
    task automatic run_search(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] tgt,
                              input int mode);
        int ef[2], eerr[2], ei[2], ndone[2], hs_cnt[2], hs_cyc[2], done_cyc[2], dly[2];
        bit pend[2];
        bit ok;
        logic [7:0] er[2], hold_p[2], cur_p[2], gres[2], e;
        logic gfound[2], gerr[2];
        logic [3:0] giters[2];
        logic [2:0] v;
        int hold_bad, fin, left;
        hold_bad = 0;
        fin = 0;
        for (int d = 0; d < 2; d++) begin
            model(d, lo, hi, tgt, ef[d], er[d], ei[d]);
            eerr[d] = 0;
            if ((mode == 1 || mode == 3) && ei[d] > 0) begin
                er[d] = (d == 0) ? exp_q0[0] : exp_q1[0];
                if (d == 0) begin while (exp_q0.size() > 1) e = exp_q0.pop_back(); end
                else begin while (exp_q1.size() > 1) e = exp_q1.pop_back(); end
                ef[d] = 0; eerr[d] = 1; ei[d] = 1;
            end
            ndone[d] = 0; hs_cnt[d] = 0; hs_cyc[d] = 0; done_cyc[d] = 0; dly[d] = 0;
            pend[d] = 1'b0;
        end
        lo_v = lo;
        hi_v = hi;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 300 && fin == 0; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (done_w[d]) begin
                    ndone[d]++;
                    done_cyc[d] = cyc;
                    gres[d] = result_w[d]; gfound[d] = found_w[d];
                    gerr[d] = err_w[d]; giters[d] = iters_w[d];
                end
                if (mode == 2 && cyc <= 10) begin
                    if (!vld_w[d] || iters_w[d] != 4'd0) hold_bad++;
                    if (cyc == 1) hold_p[d] = probe_w[d];
                    else if (probe_w[d] !== hold_p[d]) hold_bad++;
                end
                rsp_vld[d] = 1'b0; eq[d] = 1'b0; gt[d] = 1'b0; lt[d] = 1'b0;
                if (pend[d]) begin
                    if (mode != 3 && mode != 4) begin
                        if (dly[d] > 0) dly[d]--;
                        else begin
                            v = (mode == 1) ? 3'b110 : verdict(d, cur_p[d], tgt);
                            {eq[d], gt[d], lt[d]} = v;
                            rsp_vld[d] = 1'b1;
                            pend[d] = 1'b0;
                        end
                    end
                end else if ($urandom_range(3) == 0) begin
                    // Stray verdicts outside WAIT must be ignored.
                    rsp_vld[d] = 1'b1;
                    {eq[d], gt[d], lt[d]} = 3'($urandom_range(7));
                end
                if (mode == 2) rdy[d] = (cyc > 10);
                else if (mode >= 3) rdy[d] = 1'b1;
                else rdy[d] = ($urandom_range(3) != 0);
                if (vld_w[d] && rdy[d]) begin
                    hs_cnt[d]++;
                    hs_cyc[d] = cyc;
                    cur_p[d] = probe_w[d];
                    pend[d] = 1'b1;
                    dly[d] = (mode == 0) ? $urandom_range(2) : 0;
                    pop_exp(d, ok, e);
                    check_eq(tg(d, "probe"), {23'd0, 1'b1, probe_w[d]}, {23'd0, ok, e});
                end
            end
            if (mode == 4 && pend[0] && cyc > hs_cyc[0]) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                idle_inputs();
                for (int d = 0; d < 2; d++) begin
                    check_eq(tg(d, "rst_busy"), busy_w[d], 0);
                    check_eq(tg(d, "rst_vld"), vld_w[d], 0);
                    check_eq(tg(d, "rst_done"), done_w[d], 0);
                end
                @(negedge clk);
                for (int d = 0; d < 2; d++) check_eq(tg(d, "rst_no_done"), done_w[d], 0);
                fin = 1;
            end
            if (mode != 4 && ndone[0] > 0 && ndone[1] > 0 &&
                cyc >= done_cyc[0] + 2 && cyc >= done_cyc[1] + 2) fin = 1;
        end
        if (mode == 4) return;
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            check_eq(tg(d, "done_pulses"), ndone[d], 1);
            check_eq(tg(d, "found"), gfound[d], ef[d]);
            check_eq(tg(d, "err"), gerr[d], eerr[d]);
            check_eq(tg(d, "result"), gres[d], er[d]);
            check_eq(tg(d, "iters"), giters[d], ei[d]);
            check_eq(tg(d, "handshakes"), hs_cnt[d], ei[d]);
            left = (d == 0) ? exp_q0.size() : exp_q1.size();
            check_eq(tg(d, "probes_left"), left, 0);
            if (mode == 3) check_eq(tg(d, "tmo_latency"), done_cyc[d] - hs_cyc[d] - 1, 8);
        end
        if (mode == 2) check_eq("hold_stable", hold_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] lo, hi, tgt;
        rst = 1'b1;
        lo_v = '0;
        hi_v = '0;
        idle_inputs();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq(tg(d, "reset_outs"),
                     {busy_w[d], vld_w[d], done_w[d], found_w[d], err_w[d], iters_w[d]}, 0);
            check_eq(tg(d, "reset_probe"), probe_w[d], 0);
            check_eq(tg(d, "reset_result"), result_w[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_search(8'd0, 8'd255, 8'd200, 0);
        run_search(8'h80, 8'h7F, 8'hFF, 0);
        run_search(8'd10, 8'd20, 8'd5, 0);
        run_search(8'd5, 8'd5, 8'd5, 0);
        run_search(8'd20, 8'd100, 8'd77, 2);
        run_search(8'd0, 8'd100, 8'd33, 1);
`ifdef CMP_SEARCH_TIMEOUT_EN
        run_search(8'd0, 8'd100, 8'd33, 3);
`endif
        run_search(8'd0, 8'd100, 8'd33, 4);
        run_search(8'd0, 8'd100, 8'd33, 0);

        // lo > hi finishes at once; a start held through DONE is taken only once back in IDLE.
        lo_v = 8'd9;
        hi_v = 8'd3;
        start = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq(tg(d, "inv_done"), done_w[d], 1);
            check_eq(tg(d, "inv_iters"), iters_w[d], 0);
            check_eq(tg(d, "inv_found"), found_w[d], 0);
            check_eq(tg(d, "inv_result"), result_w[d], 9);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_eq(tg(d, "start_in_done"), {busy_w[d], done_w[d]}, 0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_eq(tg(d, "restart_done"), done_w[d], 1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            lo = 8'($urandom_range(255));
            hi = 8'($urandom_range(255));
            case ($urandom_range(3))
                0: tgt = lo;
                1: tgt = hi;
                default: tgt = 8'($urandom_range(255));
            endcase
            run_search(lo, hi, tgt, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
